subneg_out_uart: RTL and testbench
==================================

// Module: subneg_out_uart
// PURPOSE
//  Output stage downstream of the subneg CPU core. Captures each byte the core
//  writes to its display address (strobe + data), buffers bytes in a small FIFO,
//  and serialises them on a single UART TX pin (8N1, LSB first). Decouples the
//  CPU's 3-cycle instruction rate from the much slower serial line.
// PARAMETERS
//  CLKS_PER_BIT  104  clock cycles per UART bit period (>=2)
//  FIFO_AW       2    FIFO address width; depth = 2**FIFO_AW entries
// PORTS
//  clk        in   1  clock; all logic on rising edge
//  rst_n      in   1  reset, synchronous, active-low
//  ena        in   1  design enable; when low, new bytes are not accepted
//  out_valid  in   1  one-cycle strobe: CPU wrote display byte this cycle
//  out_data   in   8  display byte, qualified by out_valid
//  uart_tx    out  1  serial output, idle high
//  busy       out  1  high while a frame is being sent or FIFO non-empty
//  fifo_full  out  1  FIFO holds 2**FIFO_AW entries
//  overflow   out  1  sticky: a byte was dropped because FIFO was full
// BEHAVIOUR
//  Reset (rst_n low at a clk edge): uart_tx=1, busy=0, fifo_full=0, overflow=0,
//   FIFO emptied, FSM->IDLE, bit/baud counters 0. Reset mid-frame aborts the
//   frame; uart_tx is 1 from the first edge with rst_n low.
//  Push: at edge with out_valid & ena & (!full | pop_this_cycle) -> out_data
//   written at wr_ptr, wr_ptr++ (wraps mod depth). out_valid while ena=0 ignored.
//  Full drop: out_valid & ena & full & !pop -> byte discarded, overflow<=1;
//   overflow clears only on reset.
//  Simultaneous push+pop: both occur; count unchanged; push while full is
//   accepted if a pop happens the same cycle.
//  Pointers FIFO_AW+1 bits; empty = ptrs equal; full = MSBs differ, rest equal.
//  FSM states: IDLE, START, DATA, STOP.
//   IDLE : uart_tx=1. If FIFO non-empty: pop head into shift reg, baud_cnt=0,
//          ->START.
//   START: uart_tx=0 for CLKS_PER_BIT cycles, then bit_cnt=0, ->DATA.
//   DATA : uart_tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after
//          each bit; after bit_cnt=7 completes ->STOP.
//   STOP : uart_tx=1 for CLKS_PER_BIT cycles, ->IDLE.
//  baud_cnt counts 0..CLKS_PER_BIT-1, transitions on terminal count.
//  Latency: out_valid sampled at edge N with FSM IDLE and FIFO empty -> pop at
//   edge N+1 -> uart_tx low from edge N+2. Frame = 10*CLKS_PER_BIT cycles.
//  Back-to-back: exactly 1 extra idle-high cycle (IDLE) between frames.
//  busy = (state!=IDLE) | !empty, registered-equivalent (no comb path from
//   out_valid to busy within the same cycle).
//  uart_tx driven from a flop (glitch-free).
// TESTING (CLKS_PER_BIT=4, FIFO_AW=2)
//  1 Reset: hold rst_n=0 3 cycles -> uart_tx=1, busy=0, fifo_full=0, overflow=0.
//  2 Single byte: pulse out_valid, out_data=0xA5 -> uart_tx low 2 cycles later,
//    then bits 1,0,1,0,0,1,0,1 each 4 cycles, stop 4 cycles, busy drops after.
//  3 Burst: 5 strobes on consecutive cycles (0x01..0x05) -> first popped
//    immediately, remaining 4 fill FIFO, fifo_full=1, overflow=0; 5 frames sent
//    in order, each separated by exactly 1 idle cycle.
//  4 Overflow: 6 consecutive strobes -> 6th dropped, overflow=1 and stays 1
//    after all 5 frames drain; only 0x01..0x05 appear on uart_tx.
//  5 ena=0: strobe 0x3C with ena low -> no frame, busy stays 0.
//  6 Reset mid-frame: assert rst_n=0 during DATA bit 3 -> uart_tx=1 next edge,
//    FIFO empty; after release a new byte 0x80 transmits correctly.

Source files
------------

// File: rtl/subneg_out_uart.sv
// subneg_out_uart: output stage for the subneg CPU core.
// Captures display-byte strobes into a small FIFO and serialises them on a
// UART TX pin (8N1, LSB first).
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset
//   ena        - design enable; strobes ignored while low
//   out_valid  - one-cycle strobe, CPU wrote a display byte
//   out_data   - display byte qualified by out_valid
//   uart_tx    - serial output, idle high, driven from a flop
//   busy       - frame in progress or FIFO non-empty
//   fifo_full  - FIFO holds 2**FIFO_AW entries
//   overflow   - sticky, a byte was dropped because the FIFO was full
module subneg_out_uart #(
   parameter int unsigned CLKS_PER_BIT = 104,
   parameter int unsigned FIFO_AW      = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       out_valid,
   input  logic [7:0] out_data,
   output logic       uart_tx,
   output logic       busy,
   output logic       fifo_full,
   output logic       overflow
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned PTR_W = FIFO_AW + 1;
   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   baud_q, baud_d;
   logic [2:0]         bit_q, bit_d;
   logic [7:0]         shift_q, shift_d;
   logic               tx_q, tx_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic               full_q, full_d;
   logic               busy_q, busy_d;
   logic               ovf_q, ovf_d;
   logic [7:0]         mem_q [DEPTH];

   logic               empty;
   logic               baud_tc;
   logic               pop;
   logic               push;

   // State and control registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         full_q   <= 1'b0;
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         full_q   <= full_d;
         busy_q   <= busy_d;
         ovf_q    <= ovf_d;
      end
   end

   // FIFO storage; contents need no reset since pointers define validity
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[FIFO_AW-1:0]] <= out_data;
      end
   end

   // Next-state, FIFO control and registered-output logic
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = 1'b1;
      empty    = (wr_ptr_q == rd_ptr_q);
      baud_tc  = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
      pop      = (state_q == IDLE) && !empty;
      // A full FIFO still accepts a byte when the head leaves the same cycle
      push     = out_valid && ena && (!full_q || pop);
      ovf_d    = ovf_q || (out_valid && ena && full_q && !pop);
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

      case (state_q)
         IDLE: begin
            if (pop) begin
               shift_d = mem_q[rd_ptr_q[FIFO_AW-1:0]];
               baud_d  = '0;
               state_d = START;
            end
         end
         START: begin
            if (baud_tc) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               baud_d  = baud_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (baud_tc) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end
            end else begin
               baud_d  = baud_q + CNT_W'(1);
            end
         end
         STOP: begin
            if (baud_tc) begin
               baud_d  = '0;
               state_d = IDLE;
            end else begin
               baud_d  = baud_q + CNT_W'(1);
            end
         end
      endcase

      // Line level follows the current state, so it lags the FSM by one cycle
      case (state_q)
         IDLE:  tx_d = 1'b1;
         START: tx_d = 1'b0;
         DATA:  tx_d = shift_q[0];
         STOP:  tx_d = 1'b1;
      endcase

      // Flags registered from next-state values, equal to a decode of the flops
      full_d = (wr_ptr_d[FIFO_AW] != rd_ptr_d[FIFO_AW]) &&
               (wr_ptr_d[FIFO_AW-1:0] == rd_ptr_d[FIFO_AW-1:0]);
      busy_d = (state_d != IDLE) || (wr_ptr_d != rd_ptr_d);
   end

   assign uart_tx   = tx_q;
   assign busy      = busy_q;
   assign fifo_full = full_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_subneg_out_uart.sv
// Testbench for subneg_out_uart with CLKS_PER_BIT=4, FIFO_AW=2.
// A line monitor decodes frames off uart_tx and compares them against a queue
// of bytes the bench expects to be transmitted.
module tb_subneg_out_uart;

   localparam int C     = 4;
   localparam int DEPTH = 4;
   localparam int GAP   = 10 * C + 1;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic       out_valid;
   logic [7:0] out_data;
   logic       uart_tx;
   logic       busy;
   logic       fifo_full;
   logic       overflow;

   int         checks;
   int         failures;
   int         cyc;
   int         frames_done;
   logic       mon_busy;
   logic [7:0] exp_q[$];
   int         starts[$];
   logic [7:0] bb[8];

   subneg_out_uart #(.CLKS_PER_BIT(C), .FIFO_AW(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .out_valid (out_valid),
      .out_data  (out_data),
      .uart_tx   (uart_tx),
      .busy      (busy),
      .fifo_full (fifo_full),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Line monitor: one frame = 10 bit periods of C cycles each
   initial begin
      logic [7:0] expb;
      logic [7:0] got;
      logic       lvl;
      logic       aborted;
      int         bad;
      int         bi;
      mon_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && uart_tx === 1'b0) begin
            mon_busy = 1'b1;
            starts.push_back(cyc);
            if (exp_q.size() == 0) begin
               check("unexpected_frame", 32'd1, 32'd0);
               expb = 8'h00;
            end else begin
               expb = exp_q.pop_front();
            end
            bad = 0;
            got = 8'h00;
            aborted = 1'b0;
            for (int k = 0; k < 10 * C; k++) begin
               if (k > 0) begin
                  @(negedge clk);
                  if (rst_n !== 1'b1) begin
                     aborted = 1'b1;
                     break;
                  end
               end
               bi  = k / C;
               lvl = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : expb[bi-1];
               if (uart_tx !== lvl) bad++;
               if (bi >= 1 && bi <= 8 && (k % C) == C / 2) got[bi-1] = uart_tx;
            end
            if (!aborted) begin
               check("frame_data", 32'(got), 32'(expb));
               check("frame_bit_timing", 32'(bad), 32'd0);
               frames_done++;
            end
            mon_busy = 1'b0;
         end
      end
   end

   task automatic do_reset(input int n);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (n) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic strobe(input logic [7:0] d);
      @(negedge clk);
      out_valid = 1'b1;
      out_data  = d;
      @(negedge clk);
      out_valid = 1'b0;
   endtask

   // Strobes bb[0..n-1] on consecutive cycles; returns at the negedge after the last
   task automatic burst(input int n);
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         out_valid = 1'b1;
         out_data  = bb[i];
         @(negedge clk);
      end
      out_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (!(exp_q.size() == 0 && !mon_busy && busy === 1'b0) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("drain_timeout", 32'(t >= 3000), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int         f0;
      int         len;
      logic       en;
      logic       exp_ovf;
      checks      = 0;
      failures    = 0;
      cyc         = 0;
      frames_done = 0;
      rst_n       = 1'b0;
      ena         = 1'b1;
      out_valid   = 1'b0;
      out_data    = 8'h00;

      // 1 reset
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(uart_tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_full", 32'(fifo_full), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 2 single byte with latency
      exp_q.push_back(8'hA5);
      strobe(8'hA5);
      check("busy_after_push", 32'(busy), 32'd1);
      check("lat_edge_n", 32'(uart_tx), 32'd1);
      @(negedge clk);
      check("lat_edge_n1", 32'(uart_tx), 32'd1);
      @(negedge clk);
      check("lat_edge_n2", 32'(uart_tx), 32'd0);
      f0 = frames_done;
      wait_drain();
      check("single_frames", 32'(frames_done - f0), 32'd1);
      check("single_busy_idle", 32'(busy), 32'd0);
      check("single_tx_idle", 32'(uart_tx), 32'd1);

      // 3 burst of 5 fills the FIFO with no drop
      for (int i = 0; i < 5; i++) begin
         bb[i] = 8'(i + 1);
         exp_q.push_back(bb[i]);
      end
      starts.delete();
      f0 = frames_done;
      burst(5);
      check("burst_full", 32'(fifo_full), 32'd1);
      check("burst_ovf", 32'(overflow), 32'd0);
      wait_drain();
      check("burst_frames", 32'(frames_done - f0), 32'd5);
      for (int i = 1; i < 5 && i < starts.size(); i++)
         check("burst_gap", 32'(starts[i] - starts[i-1]), 32'(GAP));
      check("burst_full_after", 32'(fifo_full), 32'd0);

      // 4 six strobes: sixth is dropped
      for (int i = 0; i < 6; i++) begin
         bb[i] = 8'(i + 1);
         if (i < 5) exp_q.push_back(bb[i]);
      end
      f0 = frames_done;
      burst(6);
      check("ovf_set", 32'(overflow), 32'd1);
      wait_drain();
      check("ovf_frames", 32'(frames_done - f0), 32'd5);
      check("ovf_sticky", 32'(overflow), 32'd1);

      // 5 strobe while disabled
      f0 = frames_done;
      ena = 1'b0;
      strobe(8'h3C);
      check("ena0_busy", 32'(busy), 32'd0);
      ena = 1'b1;
      repeat (12 * C) @(negedge clk);
      check("ena0_frames", 32'(frames_done - f0), 32'd0);
      check("ena0_busy_later", 32'(busy), 32'd0);

      // 6 reset during data bit 3, then a clean frame
      exp_q.push_back(8'h5A);
      strobe(8'h5A);
      repeat (1 + 4 * C + 1) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_tx", 32'(uart_tx), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_ovf", 32'(overflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("postrst_busy", 32'(busy), 32'd0);
      check("postrst_full", 32'(fifo_full), 32'd0);
      f0 = frames_done;
      exp_q.push_back(8'h80);
      strobe(8'h80);
      wait_drain();
      check("postrst_frames", 32'(frames_done - f0), 32'd1);

      // Random bursts: accepted = first min(len, DEPTH+1) bytes when enabled
      do_reset(2);
      exp_ovf = 1'b0;
      for (int it = 0; it < 10; it++) begin
         len = int'($urandom_range(1, 6));
         en  = ($urandom_range(0, 3) != 0);
         f0  = frames_done;
         for (int i = 0; i < len; i++) begin
            bb[i] = 8'($urandom);
            if (en && i < DEPTH + 1) exp_q.push_back(bb[i]);
         end
         if (en && len > DEPTH + 1) exp_ovf = 1'b1;
         ena = en;
         burst(len);
         ena = 1'b1;
         check("rnd_full", 32'(fifo_full), 32'(en && len >= DEPTH + 1));
         wait_drain();
         check("rnd_frames", 32'(frames_done - f0), en ? 32'(len < DEPTH + 1 ? len : DEPTH + 1) : 32'd0);
         check("rnd_ovf", 32'(overflow), 32'(exp_ovf));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
